// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and default parameters for the register-file write arbiter.
// Holds the grant encoding used by the top-level port mux and the default-width
// write record {rd, data} used by software-side models of the queue.
package rf_write_arbiter_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned REGADDR_DEF  = 5;
  localparam int unsigned DEPTH_DEF    = 2;
  localparam int unsigned MAX_WAIT_DEF = 4;

  // Who owns the RF write port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_WB    = 2'd1,
    GNT_LL    = 2'd2,
    GNT_FORCE = 2'd3
  } grant_e;

  typedef struct packed {
    logic [REGADDR_DEF-1:0] rd;
    logic [XLEN_DEF-1:0]    data;
  } rf_wr_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Purpose: small synchronous FIFO of pending long-latency RF writes {rd, data}.
// Latency: a pushed entry is visible at the head on the next cycle (no bypass).
// Backpressure: full_o is registered state; caller must not push when full.
// Ports: push_i/push_rd_i/push_data_i, pop_i, full_o, empty_o, head_rd_o/head_data_o,
//        ent_rd_o (flattened rd of every slot) + ent_vld_o for hazard compares.
module rf_wb_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned REGADDR = REGADDR_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [REGADDR-1:0]         push_rd_i,
  input  logic [XLEN-1:0]            push_data_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [REGADDR-1:0]         head_rd_o,
  output logic [XLEN-1:0]            head_data_o,
  output logic [DEPTH*REGADDR-1:0]   ent_rd_o,
  output logic [DEPTH-1:0]           ent_vld_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [REGADDR-1:0] rd_mem_q   [DEPTH];
  logic [XLEN-1:0]    data_mem_q [DEPTH];
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;

  // Per-slot valid bits double as occupancy: entries are always contiguous in the ring.
  always_comb begin
    vld_d = vld_q;
    if (pop_i)  vld_d[rd_ptr_q] = 1'b0;
    if (push_i) vld_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Payload needs no reset: it is only ever observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (push_i) begin
      rd_mem_q[wr_ptr_q]   <= push_rd_i;
      data_mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign full_o      = &vld_q;
  assign empty_o     = ~|vld_q;
  assign head_rd_o   = rd_mem_q[rd_ptr_q];
  assign head_data_o = data_mem_q[rd_ptr_q];
  assign ent_vld_o   = vld_q;

  always_comb begin
    ent_rd_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd_o[i*REGADDR +: REGADDR] = rd_mem_q[i];
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Purpose: shares the RF write port between in-order writeback and queued long-latency results.
// Latency: writeback is written the same cycle; LL results no earlier than the cycle after accept.
// Backpressure: ll_ready = !full (registered); pipe_stall holds writeback on starvation-force cycles.
// Ports: wb_we/wb_rd/wb_data in, ll_valid/ll_rd/ll_data in with ll_ready out,
//        rf_we/rf_rd/rf_data out, pipe_stall out, hz_rs in / hz_hit out.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned REGADDR  = REGADDR_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wb_we,
  input  logic [REGADDR-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  input  logic               ll_valid,
  output logic               ll_ready,
  input  logic [REGADDR-1:0] ll_rd,
  input  logic [XLEN-1:0]    ll_data,
  output logic               rf_we,
  output logic [REGADDR-1:0] rf_rd,
  output logic [XLEN-1:0]    rf_data,
  output logic               pipe_stall,
  input  logic [REGADDR-1:0] hz_rs,
  output logic               hz_hit
);

  localparam int unsigned         WW       = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0]       WAIT_MAX = WW'(MAX_WAIT);

  logic                     push, pop, full, empty;
  logic                     wb_live, force_head;
  logic [REGADDR-1:0]       head_rd;
  logic [XLEN-1:0]          head_data;
  logic [DEPTH*REGADDR-1:0] ent_rd;
  logic [DEPTH-1:0]         ent_vld;
  logic [WW-1:0]            wait_q, wait_d;
  grant_e                   gnt;

  rf_wb_fifo #(
    .XLEN    (XLEN),
    .REGADDR (REGADDR),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_rd_i   (ll_rd),
    .push_data_i (ll_data),
    .pop_i       (pop),
    .full_o      (full),
    .empty_o     (empty),
    .head_rd_o   (head_rd),
    .head_data_o (head_data),
    .ent_rd_o    (ent_rd),
    .ent_vld_o   (ent_vld)
  );

  // rd==0 writes are architecturally void: wb leaves the slot free, LL is accepted but dropped.
  assign wb_live    = wb_we && (wb_rd != '0);
  assign ll_ready   = rst_n && !full;
  assign push       = ll_valid && ll_ready && (ll_rd != '0);
  assign force_head = !empty && (wait_q == WAIT_MAX);

  always_comb begin
    gnt = GNT_NONE;
    if (force_head)   gnt = GNT_FORCE;
    else if (wb_live) gnt = GNT_WB;
    else if (!empty)  gnt = GNT_LL;
  end

  assign pop        = (gnt == GNT_FORCE) || (gnt == GNT_LL);
  // rst_n gating keeps a live wb request from reaching the RF while held in reset.
  assign rf_we      = rst_n && (gnt != GNT_NONE);
  assign pipe_stall = rst_n && (gnt == GNT_FORCE);
  assign rf_rd      = (gnt == GNT_WB) ? wb_rd   : head_rd;
  assign rf_data    = (gnt == GNT_WB) ? wb_data : head_data;

  // Counts consecutive cycles the head has been denied; saturates so force holds until the pop.
  always_comb begin
    wait_d = wait_q;
    if (pop || empty)             wait_d = '0;
    else if (wait_q != WAIT_MAX)  wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end

  // Registered valids: covers the entry popping now, not the one being pushed now.
  always_comb begin
    hz_hit = 1'b0;
    if (hz_rs != '0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_vld[i] && (ent_rd[i*REGADDR +: REGADDR] == hz_rs)) hz_hit = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
  import rf_write_arbiter_pkg::*;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we, ll_valid, ll_ready, rf_we, pipe_stall, hz_hit;
  logic [4:0]  wb_rd, ll_rd, rf_rd, hz_rs;
  logic [31:0] wb_data, ll_data, rf_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(
    .XLEN(32), .REGADDR(5), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
    .pipe_stall(pipe_stall), .hz_rs(hz_rs), .hz_hit(hz_hit)
  );

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ll_valid;
    logic [4:0]  ll_rd;
    logic [31:0] ll_data;
    logic [4:0]  hz_rs;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_stall;
    logic        e_ready;
    logic        e_hit;
  } vec_t;

  vec_t   tbl[$];
  rf_wr_t mq[$];
  int     mwait;

  function automatic vec_t mk(input logic w, input logic [4:0] wr, input logic [31:0] wd,
                              input logic l, input logic [4:0] lr, input logic [31:0] ld,
                              input logic [4:0] hz, input logic ewe, input logic [4:0] erd,
                              input logic [31:0] edat, input logic est, input logic erdy,
                              input logic ehit);
    vec_t v;
    v.wb_we = w; v.wb_rd = wr; v.wb_data = wd;
    v.ll_valid = l; v.ll_rd = lr; v.ll_data = ld; v.hz_rs = hz;
    v.e_we = ewe; v.e_rd = erd; v.e_data = edat;
    v.e_stall = est; v.e_ready = erdy; v.e_hit = ehit;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic w, input logic [4:0] wr, input logic [31:0] wd,
                     input logic l, input logic [4:0] lr, input logic [31:0] ld,
                     input logic [4:0] hz);
    wb_we = w; wb_rd = wr; wb_data = wd;
    ll_valid = l; ll_rd = lr; ll_data = ld; hz_rs = hz;
  endtask

  // Drive at the falling edge, let combinational outputs settle, sample before the rising edge.
  task automatic step(input logic w, input logic [4:0] wr, input logic [31:0] wd,
                      input logic l, input logic [4:0] lr, input logic [31:0] ld,
                      input logic [4:0] hz);
    @(negedge clk);
    drv(w, wr, wd, l, lr, ld, hz);
    #1;
  endtask

  initial begin
    // ---------------- reset with live requests ----------------
    rst_n = 1'b0;
    drv(1'b1, 5'd5, 32'hA5, 1'b1, 5'd6, 32'h66, 5'd6);
    repeat (2) @(negedge clk);
    #1;
    chk("rst rf_we", rf_we, 0);
    chk("rst ll_ready", ll_ready, 0);
    chk("rst pipe_stall", pipe_stall, 0);
    chk("rst hz_hit", hz_hit, 0);
    @(negedge clk);
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
    rst_n = 1'b1;
    #1;
    chk("rel ll_ready", ll_ready, 1);
    chk("rel rf_we", rf_we, 0);

    // ---------------- directed table ----------------
    //            wb_we rd     data        llv rd     data         hz     we  rd     data        st  rdy hit
    tbl.push_back(mk(1, 5'd5,  32'hA5,      0, 5'd0,  32'h0,      5'd0,  1, 5'd5,  32'hA5,     0, 1, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,       1, 5'd7,  32'h1234,   5'd7,  0, 5'd0,  32'h0,      0, 1, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,       0, 5'd0,  32'h0,      5'd7,  1, 5'd7,  32'h1234,   0, 1, 1));
    tbl.push_back(mk(0, 5'd0,  32'h0,       0, 5'd0,  32'h0,      5'd7,  0, 5'd0,  32'h0,      0, 1, 0));
    tbl.push_back(mk(1, 5'd9,  32'h99,      1, 5'd3,  32'h33,     5'd3,  1, 5'd9,  32'h99,     0, 1, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1, 5'd9, 32'h99,     0, 5'd0,  32'h0,      5'd3,  1, 5'd9,  32'h99,     0, 1, 1));
    tbl.push_back(mk(1, 5'd9,  32'h99,      0, 5'd0,  32'h0,      5'd3,  1, 5'd3,  32'h33,     1, 1, 1));
    tbl.push_back(mk(1, 5'd9,  32'h99,      0, 5'd0,  32'h0,      5'd3,  1, 5'd9,  32'h99,     0, 1, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,       1, 5'd0,  32'hDEAD,   5'd0,  0, 5'd0,  32'h0,      0, 1, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,       0, 5'd0,  32'h0,      5'd0,  0, 5'd0,  32'h0,      0, 1, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,       1, 5'd4,  32'h44,     5'd4,  0, 5'd0,  32'h0,      0, 1, 0));
    tbl.push_back(mk(1, 5'd10, 32'h10,      0, 5'd0,  32'h0,      5'd4,  1, 5'd10, 32'h10,     0, 1, 1));
    tbl.push_back(mk(0, 5'd0,  32'h0,       0, 5'd0,  32'h0,      5'd4,  1, 5'd4,  32'h44,     0, 1, 1));
    tbl.push_back(mk(0, 5'd0,  32'h0,       0, 5'd0,  32'h0,      5'd4,  0, 5'd0,  32'h0,      0, 1, 0));
    tbl.push_back(mk(1, 5'd0,  32'hFF,      0, 5'd0,  32'h0,      5'd0,  0, 5'd0,  32'h0,      0, 1, 0));

    foreach (tbl[i]) begin
      step(tbl[i].wb_we, tbl[i].wb_rd, tbl[i].wb_data,
           tbl[i].ll_valid, tbl[i].ll_rd, tbl[i].ll_data, tbl[i].hz_rs);
      chk($sformatf("v%0d rf_we", i), rf_we, tbl[i].e_we);
      if (tbl[i].e_we) begin
        chk($sformatf("v%0d rf_rd", i), rf_rd, tbl[i].e_rd);
        chk($sformatf("v%0d rf_data", i), rf_data, tbl[i].e_data);
      end
      chk($sformatf("v%0d pipe_stall", i), pipe_stall, tbl[i].e_stall);
      chk($sformatf("v%0d ll_ready", i), ll_ready, tbl[i].e_ready);
      chk($sformatf("v%0d hz_hit", i), hz_hit, tbl[i].e_hit);
    end

    // ---------------- full FIFO under a continuous wb stream ----------------
    step(1, 5'd20, 32'h20, 1, 5'd1, 32'h11, 5'd0);
    chk("full a ready", ll_ready, 1);
    step(1, 5'd20, 32'h20, 1, 5'd2, 32'h22, 5'd0);
    chk("full b ready", ll_ready, 1);
    for (int k = 0; k < 3; k++) begin
      step(1, 5'd20, 32'h20, 1, 5'd3, 32'h33, 5'd0);
      chk($sformatf("full c%0d ready", k), ll_ready, 0);
      chk($sformatf("full c%0d rf_rd", k), rf_rd, 20);
    end
    step(1, 5'd20, 32'h20, 1, 5'd3, 32'h33, 5'd0);
    chk("full force stall", pipe_stall, 1);
    chk("full force rd", rf_rd, 1);
    chk("full force data", rf_data, 32'h11);
    chk("full force ready", ll_ready, 0);
    step(1, 5'd20, 32'h20, 1, 5'd3, 32'h33, 5'd0);
    chk("full after-pop ready", ll_ready, 1);
    chk("full after-pop rd", rf_rd, 20);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd3);
    chk("drain1 rd", rf_rd, 2);
    chk("drain1 hz", hz_hit, 1);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd3);
    chk("drain2 rd", rf_rd, 3);
    chk("drain2 data", rf_data, 32'h33);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd3);
    chk("drain3 rf_we", rf_we, 0);

    // ---------------- reset mid-operation discards the queue ----------------
    step(1, 5'd20, 32'h20, 1, 5'd8, 32'h88, 5'd8);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst rf_we", rf_we, 0);
    chk("midrst hz_hit", hz_hit, 0);
    chk("midrst ll_ready", ll_ready, 0);
    @(negedge clk);
    drv(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd8);
    rst_n = 1'b1;
    #1;
    chk("postrst rf_we", rf_we, 0);
    chk("postrst hz_hit", hz_hit, 0);
    chk("postrst ll_ready", ll_ready, 1);

    // ---------------- randomized against a queue model ----------------
    mq.delete();
    mwait = 0;
    for (int c = 0; c < 800; c++) begin
      logic        w, l, e_we, e_st, e_rdy, e_hit, frc, live, popd;
      logic [4:0]  wr, lr, hz, e_rd;
      logic [31:0] wd, ld, e_dat;
      int          sz;
      w  = ($urandom_range(0, 9) < 7);
      wr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
      wd = $urandom;
      l  = ($urandom_range(0, 2) != 0);
      lr = 5'($urandom_range(0, 15));
      ld = $urandom;
      hz = 5'($urandom_range(0, 15));
      step(w, wr, wd, l, lr, ld, hz);

      sz    = mq.size();
      e_rdy = (sz < DEPTH);
      e_hit = 1'b0;
      if (hz != 0) foreach (mq[k]) if (mq[k].rd == hz) e_hit = 1'b1;
      frc   = (sz > 0) && (mwait == MAX_WAIT);
      live  = w && (wr != 0);
      e_we = 0; e_st = 0; e_rd = 0; e_dat = 0; popd = 0;
      if (frc) begin
        e_we = 1; e_st = 1; e_rd = mq[0].rd; e_dat = mq[0].data; popd = 1;
      end else if (live) begin
        e_we = 1; e_rd = wr; e_dat = wd;
      end else if (sz > 0) begin
        e_we = 1; e_rd = mq[0].rd; e_dat = mq[0].data; popd = 1;
      end

      chk($sformatf("rnd%0d rf_we", c), rf_we, e_we);
      if (e_we) begin
        chk($sformatf("rnd%0d rf_rd", c), rf_rd, e_rd);
        chk($sformatf("rnd%0d rf_data", c), rf_data, e_dat);
      end
      chk($sformatf("rnd%0d pipe_stall", c), pipe_stall, e_st);
      chk($sformatf("rnd%0d ll_ready", c), ll_ready, e_rdy);
      chk($sformatf("rnd%0d hz_hit", c), hz_hit, e_hit);

      if (popd || sz == 0) mwait = 0;
      else if (mwait < MAX_WAIT) mwait++;
      if (popd) void'(mq.pop_front());
      if (l && e_rdy && lr != 0) mq.push_back('{rd: lr, data: ld});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
